// File: rtl/feed_arbiter_pkg.sv
// feed_arbiter_pkg: FSM state encoding and bus width shared by the feed arbiter files
package feed_arbiter_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam int DATA_W = 32;
endpackage

// File: rtl/feed_arbiter_rr_pick.sv
// feed_arbiter_rr_pick: combinational round-robin pick of the first request after last_i
// Ports: req_i request mask, last_i previous grant, gnt_id_o picked index, any_o some request set
module feed_arbiter_rr_pick
  import feed_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_W-1:0]   last_i,
  output logic [SRC_W-1:0]   gnt_id_o,
  output logic               any_o
);
  // Scan from the farthest candidate to the nearest so the nearest request wins.
  always_comb begin
    logic [SRC_W-1:0] idx;
    idx = '0;
    gnt_id_o = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = SRC_W'((int'(last_i) + k) % NUM_SRC);
      if (req_i[idx]) gnt_id_o = idx;
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/feed_arbiter.sv
// feed_arbiter: frame-locked round-robin mux of NUM_SRC AXI-Stream feeds onto one 32-bit stream
// Ports: s_axis_* per-source inputs/ready, src_enable eligibility mask, m_axis_* merged output,
//        grant_id current/last grant, busy (XFER or DROP), trunc_pulse one cycle after a forced tlast
module feed_arbiter
  import feed_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = $clog2(NUM_SRC),
  parameter int MAX_WORDS = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  input  logic [NUM_SRC-1:0]        src_enable,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [SRC_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      trunc_pulse
);
  localparam int CNT_W = $clog2(MAX_WORDS);
  logic [1:0] state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] src_data [NUM_SRC];
  logic trunc_q, trunc_d, any, idle, xfer, drop, at_max, src_last, hs_x, hs_d;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_data[i] = s_axis_tdata[DATA_W*i +: DATA_W];
  end
  feed_arbiter_rr_pick #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_pick (
    .req_i(s_axis_tvalid & src_enable),
    .last_i(last_q),
    .gnt_id_o(pick),
    .any_o(any)
  );
  always_comb begin
    idle = state_q == IDLE;
    xfer = state_q == XFER;
    drop = state_q == DROP;
    at_max = cnt_q == CNT_W'(MAX_WORDS - 1);
    src_last = s_axis_tlast[grant_q];
    m_axis_tdata = xfer ? src_data[grant_q] : '0;
    m_axis_tvalid = xfer & s_axis_tvalid[grant_q];
    m_axis_tlast = xfer & (src_last | at_max);
    // DROP drains the runaway source regardless of downstream back-pressure.
    s_axis_tready = xfer ? NUM_SRC'(m_axis_tready) << grant_q : drop ? NUM_SRC'(1) << grant_q : '0;
    hs_x = m_axis_tvalid & m_axis_tready;
    hs_d = drop & s_axis_tvalid[grant_q];
    state_d = idle ? (any ? XFER : IDLE)
            : xfer ? (hs_x & src_last ? IDLE : hs_x & at_max ? DROP : XFER)
            : (hs_d & src_last ? IDLE : DROP);
    cnt_d = hs_x ? ((src_last | at_max) ? '0 : cnt_q + 1'b1) : cnt_q;
    trunc_d = hs_x & ~src_last & at_max;
    grant_d = idle & any ? pick : grant_q;
    last_d = idle & any ? pick : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= SRC_W'(NUM_SRC - 1);
      cnt_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      trunc_q <= trunc_d;
    end
  end
  assign grant_id = grant_q;
  assign busy = ~idle;
  assign trunc_pulse = trunc_q;
endmodule
